// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
// Groups the DEC, EXE, later-stage forwarding and long-latency completion
// signals seen by the DEC-stage hazard unit, plus the unit's results.
//
// Parameters: XLEN (datapath width), NUM_RS (DEC source operands),
//             NUM_FWD (forwarding stages after EXE).
// Modports:
//   master - pipeline side: drives DEC/EXE/forward/completion info,
//            receives stall flags, operand data and scoreboard state.
//   slave  - hazard unit side (hazard_scoreboard).
interface hazard_scoreboard_if #(
   parameter int XLEN    = 32,
   parameter int NUM_RS  = 2,
   parameter int NUM_FWD = 2
);
   logic                     dec_valid;
   logic [5*NUM_RS-1:0]      dec_rs;
   logic [NUM_RS-1:0]        dec_rs_renb;
   logic [XLEN*NUM_RS-1:0]   dec_rdata;
   logic [4:0]               dec_rd;
   logic                     dec_rd_wenb;
   logic                     dec_long;
   logic                     dec_flush;

   logic [4:0]               exe_rd;
   logic                     exe_rd_wenb;
   logic [XLEN-1:0]          exe_result;
   logic                     exe_load;
   logic                     exe_csr;

   logic [5*NUM_FWD-1:0]     fwd_rd;
   logic [NUM_FWD-1:0]       fwd_wenb;
   logic [XLEN*NUM_FWD-1:0]  fwd_result;

   logic                     lng_cpl_valid;
   logic [4:0]               lng_cpl_rd;
   logic [XLEN-1:0]          lng_cpl_result;

   logic                     dec_stall;
   logic                     dec_load_use;
   logic                     dec_csr_use;
   logic                     dec_sb_use;
   logic [XLEN*NUM_RS-1:0]   dec_rs_data;
   logic [31:0]              sb_pending;
   logic [31:0]              stall_cycles;

   modport master (
      output dec_valid, dec_rs, dec_rs_renb, dec_rdata, dec_rd, dec_rd_wenb,
             dec_long, dec_flush,
             exe_rd, exe_rd_wenb, exe_result, exe_load, exe_csr,
             fwd_rd, fwd_wenb, fwd_result,
             lng_cpl_valid, lng_cpl_rd, lng_cpl_result,
      input  dec_stall, dec_load_use, dec_csr_use, dec_sb_use, dec_rs_data,
             sb_pending, stall_cycles
   );

   modport slave (
      input  dec_valid, dec_rs, dec_rs_renb, dec_rdata, dec_rd, dec_rd_wenb,
             dec_long, dec_flush,
             exe_rd, exe_rd_wenb, exe_result, exe_load, exe_csr,
             fwd_rd, fwd_wenb, fwd_result,
             lng_cpl_valid, lng_cpl_rd, lng_cpl_result,
      output dec_stall, dec_load_use, dec_csr_use, dec_sb_use, dec_rs_data,
             sb_pending, stall_cycles
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// DEC-stage hazard unit: forwards EXE / later-stage / long-op completion
// results to every DEC source operand, stalls DEC on load-use, CSR-use,
// scoreboard (RAW and WAW on long-latency destinations) and
// outstanding-limit hazards, and tracks pending long-latency destinations.
//
// Ports:
//   clk    - core clock
//   rst_n  - asynchronous active-low reset
//   bus    - hazard_scoreboard_if.slave carrying all DEC/EXE/forward/
//            completion inputs and the stall, operand, sb_pending and
//            stall_cycles outputs
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating
// stall-cycle counter; otherwise stall_cycles is tied to zero.
module hazard_scoreboard #(
   parameter int XLEN      = 32,
   parameter int NUM_RS    = 2,
   parameter int NUM_FWD   = 2,
   parameter int LNG_DEPTH = 2
) (
   input logic             clk,
   input logic             rst_n,
   hazard_scoreboard_if.slave bus
);

   localparam logic [3:0] DEPTH = LNG_DEPTH[3:0];

   logic [31:0]            sb_pending_q;
   logic [31:0]            sb_pending_d;
   logic [3:0]             outstanding_q;
   logic [3:0]             outstanding_d;

   logic [NUM_RS-1:0]      load_hit;
   logic [NUM_RS-1:0]      csr_hit;
   logic [NUM_RS-1:0]      sb_hit;
   logic [XLEN-1:0]        src_data [NUM_RS];
   logic [XLEN*NUM_RS-1:0] rs_data_packed;

   logic                   cpl_on_dec_rd;
   logic                   waw_hit;
   logic                   depth_hit;
   logic                   load_use;
   logic                   csr_use;
   logic                   sb_use;
   logic                   stall;
   logic                   issue;

   genvar g;
   for (g = 0; g < NUM_RS; g++) begin : g_src
      logic [4:0]      rs;
      logic            used;
      logic            exe_match;
      logic            cpl_match;
      logic [XLEN-1:0] data;

      // x0 is excluded here, so it can neither forward nor stall.
      assign rs        = bus.dec_rs[5*g +: 5];
      assign used      = bus.dec_rs_renb[g] && (rs != 5'd0);
      assign exe_match = used && bus.exe_rd_wenb && (bus.exe_rd == rs);
      assign cpl_match = used && bus.lng_cpl_valid && (bus.lng_cpl_rd == rs);

      // Operand mux built lowest priority first so that later assignments
      // (nearer stages) win. A load/CSR in EXE has no result yet, so it is
      // never forwarded; the stall covers that case.
      always_comb begin
         data = bus.dec_rdata[XLEN*g +: XLEN];
         if (cpl_match) begin
            data = bus.lng_cpl_result;
         end
         for (int f = NUM_FWD - 1; f >= 0; f--) begin
            if (used && bus.fwd_wenb[f] && (bus.fwd_rd[5*f +: 5] == rs)) begin
               data = bus.fwd_result[XLEN*f +: XLEN];
            end
         end
         if (exe_match && !bus.exe_load && !bus.exe_csr) begin
            data = bus.exe_result;
         end
      end

      assign src_data[g] = data;
      assign load_hit[g] = exe_match && bus.exe_load;
      assign csr_hit[g]  = exe_match && bus.exe_csr;
      // A same-cycle completion both forwards and releases the register.
      assign sb_hit[g]   = used && sb_pending_q[rs] && !cpl_match;
   end

   always_comb begin
      rs_data_packed = '0;
      for (int i = 0; i < NUM_RS; i++) begin
         rs_data_packed[XLEN*i +: XLEN] = src_data[i];
      end
   end

   // Destination-side and structural hazards against the scoreboard.
   assign cpl_on_dec_rd = bus.lng_cpl_valid && (bus.lng_cpl_rd == bus.dec_rd);
   assign waw_hit       = bus.dec_rd_wenb && sb_pending_q[bus.dec_rd] && !cpl_on_dec_rd;
   assign depth_hit     = bus.dec_long && (outstanding_q == DEPTH) && !bus.lng_cpl_valid;

   assign load_use = bus.dec_valid && (|load_hit);
   assign csr_use  = bus.dec_valid && (|csr_hit);
   assign sb_use   = bus.dec_valid && ((|sb_hit) || waw_hit || depth_hit);
   assign stall    = load_use || csr_use || sb_use;

   assign issue = bus.dec_valid && bus.dec_long && bus.dec_rd_wenb && !stall &&
                  !bus.dec_flush && (bus.dec_rd != 5'd0);

   // Next scoreboard state: clear on completion first so that an issue to
   // the same register in the same cycle leaves the bit set. The outstanding
   // count saturates at zero so stray completions after a reset are harmless.
   always_comb begin
      sb_pending_d  = sb_pending_q;
      outstanding_d = outstanding_q;
      if (bus.lng_cpl_valid) begin
         sb_pending_d[bus.lng_cpl_rd] = 1'b0;
      end
      if (issue) begin
         sb_pending_d[bus.dec_rd] = 1'b1;
      end
      sb_pending_d[0] = 1'b0;
      if (issue && !bus.lng_cpl_valid) begin
         outstanding_d = outstanding_q + 4'd1;
      end else if (!issue && bus.lng_cpl_valid && (outstanding_q != 4'd0)) begin
         outstanding_d = outstanding_q - 4'd1;
      end
   end

   // Scoreboard state registers; flush never touches them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_pending_q  <= '0;
         outstanding_q <= '0;
      end else begin
         sb_pending_q  <= sb_pending_d;
         outstanding_q <= outstanding_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q;

   // Saturating count of stalled DEC cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign bus.stall_cycles = stall_cnt_q;
`else
   assign bus.stall_cycles = '0;
`endif

   assign bus.dec_stall    = stall;
   assign bus.dec_load_use = load_use;
   assign bus.dec_csr_use  = csr_use;
   assign bus.dec_sb_use   = sb_use;
   assign bus.dec_rs_data  = rs_data_packed;
   assign bus.sb_pending   = sb_pending_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Self-checking bench for hazard_scoreboard (XLEN=32, NUM_RS=2, NUM_FWD=2,
// LNG_DEPTH=2). A behavioural reference model produces the expected outputs
// for each driven cycle; they are queued when the stimulus is applied and
// popped and compared when the outputs are sampled. Directed constant checks
// anchor the key scenarios. Honours HAZARD_PERF_CNT_EN for stall_cycles.
module tb_hazard_scoreboard;

   localparam int XLEN      = 32;
   localparam int NUM_RS    = 2;
   localparam int NUM_FWD   = 2;
   localparam int LNG_DEPTH = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   hazard_scoreboard_if #(.XLEN(XLEN), .NUM_RS(NUM_RS), .NUM_FWD(NUM_FWD)) bus ();

   hazard_scoreboard #(
      .XLEN(XLEN), .NUM_RS(NUM_RS), .NUM_FWD(NUM_FWD), .LNG_DEPTH(LNG_DEPTH)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        stall;
      logic        loadUse;
      logic        csrUse;
      logic        sbUse;
      logic [63:0] data;
      logic [31:0] pend;
      logic [31:0] cnt;
   } exp_t;

   exp_t        expQ[$];
   exp_t        lastExp;
   logic [31:0] pendM;
   int          outM;
   logic [31:0] cntM;
   int          testsRun  = 0;
   int          failCount = 0;
   string       phase     = "init";

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [31:0] PERF_FOUR = 32'd4;
`else
   localparam logic [31:0] PERF_FOUR = 32'd0;
`endif

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s.%s: observed %0h expected %0h", phase, tag, observed, expected);
      end
   endtask

   task automatic clearInputs();
      bus.dec_valid      = 1'b0;
      bus.dec_rs         = '0;
      bus.dec_rs_renb    = '0;
      bus.dec_rdata      = '0;
      bus.dec_rd         = '0;
      bus.dec_rd_wenb    = 1'b0;
      bus.dec_long       = 1'b0;
      bus.dec_flush      = 1'b0;
      bus.exe_rd         = '0;
      bus.exe_rd_wenb    = 1'b0;
      bus.exe_result     = '0;
      bus.exe_load       = 1'b0;
      bus.exe_csr        = 1'b0;
      bus.fwd_rd         = '0;
      bus.fwd_wenb       = '0;
      bus.fwd_result     = '0;
      bus.lng_cpl_valid  = 1'b0;
      bus.lng_cpl_rd     = '0;
      bus.lng_cpl_result = '0;
   endtask

   task automatic modelReset();
      pendM = '0;
      outM  = 0;
      cntM  = '0;
   endtask

   // Reference model of the combinational outputs: search stages from the
   // highest priority down and stop at the first usable hit.
   function automatic exp_t modelOut();
      exp_t        e;
      logic [4:0]  rs;
      logic [31:0] d;
      logic        found, cplHit, sbAny, lu, cu, waw, depthFull;
      e     = '0;
      sbAny = 1'b0;
      lu    = 1'b0;
      cu    = 1'b0;
      for (int i = 0; i < NUM_RS; i++) begin
         rs    = bus.dec_rs[5*i +: 5];
         d     = bus.dec_rdata[32*i +: 32];
         found = 1'b0;
         if (bus.dec_rs_renb[i] && rs != 5'd0) begin
            cplHit = bus.lng_cpl_valid && bus.lng_cpl_rd == rs;
            if (bus.exe_rd_wenb && bus.exe_rd == rs) begin
               if (bus.exe_load) lu = 1'b1;
               if (bus.exe_csr)  cu = 1'b1;
               if (!bus.exe_load && !bus.exe_csr) begin
                  d     = bus.exe_result;
                  found = 1'b1;
               end
            end
            for (int f = 0; f < NUM_FWD; f++) begin
               if (!found && bus.fwd_wenb[f] && bus.fwd_rd[5*f +: 5] == rs) begin
                  d     = bus.fwd_result[32*f +: 32];
                  found = 1'b1;
               end
            end
            if (!found && cplHit) d = bus.lng_cpl_result;
            if (pendM[rs] && !cplHit) sbAny = 1'b1;
         end
         e.data[32*i +: 32] = d;
      end
      waw = bus.dec_rd_wenb && pendM[bus.dec_rd] &&
            !(bus.lng_cpl_valid && bus.lng_cpl_rd == bus.dec_rd);
      depthFull = bus.dec_long && (outM == LNG_DEPTH) && !bus.lng_cpl_valid;
      e.loadUse = bus.dec_valid && lu;
      e.csrUse  = bus.dec_valid && cu;
      e.sbUse   = bus.dec_valid && (sbAny || waw || depthFull);
      e.stall   = e.loadUse || e.csrUse || e.sbUse;
      e.pend    = pendM;
      e.cnt     = cntM;
      return e;
   endfunction

   // Queue the expectation for the current inputs, then compare at negedge.
   task automatic applyStimulus();
      exp_t e;
      expQ.push_back(modelOut());
      @(negedge clk);
      e       = expQ.pop_front();
      lastExp = e;
      checkOutput("dec_stall",    64'(bus.dec_stall),    64'(e.stall));
      checkOutput("dec_load_use", 64'(bus.dec_load_use), 64'(e.loadUse));
      checkOutput("dec_csr_use",  64'(bus.dec_csr_use),  64'(e.csrUse));
      checkOutput("dec_sb_use",   64'(bus.dec_sb_use),   64'(e.sbUse));
      checkOutput("sb_pending",   64'(bus.sb_pending),   64'(e.pend));
      checkOutput("stall_cycles", 64'(bus.stall_cycles), 64'(e.cnt));
      if (!e.stall) begin
         checkOutput("dec_rs_data", bus.dec_rs_data, e.data);
      end
   endtask

   // Advance the model state on the clock edge the DUT registers on.
   task automatic advanceClock();
      logic issue;
      @(posedge clk);
      if (rst_n) begin
         issue = bus.dec_valid && bus.dec_long && bus.dec_rd_wenb && !lastExp.stall &&
                 !bus.dec_flush && bus.dec_rd != 5'd0;
         if (bus.lng_cpl_valid) pendM[bus.lng_cpl_rd] = 1'b0;
         if (issue) pendM[bus.dec_rd] = 1'b1;
         pendM[0] = 1'b0;
         if (issue && !bus.lng_cpl_valid) outM++;
         else if (!issue && bus.lng_cpl_valid && outM > 0) outM--;
`ifdef HAZARD_PERF_CNT_EN
         if (lastExp.stall && cntM != 32'hFFFF_FFFF) cntM++;
`endif
      end
      #1;
   endtask

   task automatic issueLong(input logic [4:0] rd);
      clearInputs();
      bus.dec_valid   = 1'b1;
      bus.dec_long    = 1'b1;
      bus.dec_rd_wenb = 1'b1;
      bus.dec_rd      = rd;
   endtask

   initial begin
      clearInputs();
      modelReset();
      lastExp = '0;

      phase = "reset";
      repeat (2) @(posedge clk);
      #1;
      checkOutput("sb_pending", 64'(bus.sb_pending), 64'd0);
      checkOutput("stall_cycles", 64'(bus.stall_cycles), 64'd0);
      rst_n = 1'b1;

      // Load in EXE feeding rs2: four stalled cycles.
      phase = "load_use";
      bus.dec_valid     = 1'b1;
      bus.dec_rs[9:5]   = 5'd7;
      bus.dec_rs_renb   = 2'b10;
      bus.exe_rd        = 5'd7;
      bus.exe_rd_wenb   = 1'b1;
      bus.exe_load      = 1'b1;
      for (int k = 0; k < 4; k++) begin
         applyStimulus();
         if (k == 0) begin
            checkOutput("tp_stall", 64'(bus.dec_stall), 64'd1);
            checkOutput("tp_load_use", 64'(bus.dec_load_use), 64'd1);
         end
         advanceClock();
      end
      bus.exe_load = 1'b0;
      bus.exe_rd_wenb = 1'b0;
      applyStimulus();
      checkOutput("tp_perf_count", 64'(bus.stall_cycles), 64'(PERF_FOUR));
      advanceClock();

      phase = "x0_no_stall";
      bus.dec_rs[9:5] = 5'd0;
      bus.exe_rd      = 5'd0;
      bus.exe_rd_wenb = 1'b1;
      bus.exe_load    = 1'b1;
      applyStimulus();
      checkOutput("tp_stall", 64'(bus.dec_stall), 64'd0);
      advanceClock();

      phase = "csr_use";
      clearInputs();
      bus.dec_valid   = 1'b1;
      bus.dec_rs[4:0] = 5'd12;
      bus.dec_rs_renb = 2'b01;
      bus.exe_rd      = 5'd12;
      bus.exe_rd_wenb = 1'b1;
      bus.exe_csr     = 1'b1;
      applyStimulus();
      checkOutput("tp_csr_use", 64'(bus.dec_csr_use), 64'd1);
      advanceClock();

      // Forward priority: EXE > fwd[0] > fwd[1] > completion > register file.
      phase = "forward";
      clearInputs();
      bus.dec_valid       = 1'b1;
      bus.dec_rs[4:0]     = 5'd5;
      bus.dec_rs_renb     = 2'b01;
      bus.dec_rdata       = {32'h2222_2222, 32'h1111_1111};
      bus.exe_rd          = 5'd5;
      bus.exe_rd_wenb     = 1'b1;
      bus.exe_result      = 32'hAA;
      bus.fwd_rd          = {5'd5, 5'd5};
      bus.fwd_wenb        = 2'b11;
      bus.fwd_result      = {32'hCC, 32'hBB};
      bus.lng_cpl_valid   = 1'b1;
      bus.lng_cpl_rd      = 5'd5;
      bus.lng_cpl_result  = 32'h55;
      applyStimulus();
      checkOutput("tp_exe", 64'(bus.dec_rs_data[31:0]), 64'hAA);
      checkOutput("tp_stall", 64'(bus.dec_stall), 64'd0);
      advanceClock();
      bus.exe_rd_wenb = 1'b0;
      applyStimulus();
      checkOutput("tp_fwd0", 64'(bus.dec_rs_data[31:0]), 64'hBB);
      advanceClock();
      bus.fwd_wenb = 2'b10;
      applyStimulus();
      checkOutput("tp_fwd1", 64'(bus.dec_rs_data[31:0]), 64'hCC);
      advanceClock();
      bus.fwd_wenb = 2'b00;
      applyStimulus();
      checkOutput("tp_cpl", 64'(bus.dec_rs_data[31:0]), 64'h55);
      advanceClock();
      bus.lng_cpl_valid = 1'b0;
      applyStimulus();
      checkOutput("tp_rf", 64'(bus.dec_rs_data[31:0]), 64'h1111_1111);
      advanceClock();

      // Divider to x9, then a dependent read that waits for completion.
      phase = "div";
      issueLong(5'd9);
      applyStimulus();
      advanceClock();
      clearInputs();
      bus.dec_valid   = 1'b1;
      bus.dec_rs[4:0] = 5'd9;
      bus.dec_rs_renb = 2'b01;
      bus.dec_rdata   = {32'h0, 32'hDEAD};
      for (int k = 0; k < 2; k++) begin
         applyStimulus();
         checkOutput("tp_sb_use", 64'(bus.dec_sb_use), 64'd1);
         advanceClock();
      end
      bus.lng_cpl_valid  = 1'b1;
      bus.lng_cpl_rd     = 5'd9;
      bus.lng_cpl_result = 32'h1234;
      applyStimulus();
      checkOutput("tp_cpl_fwd", 64'(bus.dec_rs_data[31:0]), 64'h1234);
      checkOutput("tp_cpl_stall", 64'(bus.dec_stall), 64'd0);
      advanceClock();
      bus.lng_cpl_valid = 1'b0;
      applyStimulus();
      checkOutput("tp_x9_clear", 64'(bus.sb_pending[9]), 64'd0);
      advanceClock();

      // Outstanding limit with LNG_DEPTH = 2.
      phase = "depth";
      issueLong(5'd3); applyStimulus(); advanceClock();
      issueLong(5'd4); applyStimulus(); advanceClock();
      issueLong(5'd5);
      applyStimulus();
      checkOutput("tp_full_stall", 64'(bus.dec_sb_use), 64'd1);
      advanceClock();
      bus.lng_cpl_valid = 1'b1;
      bus.lng_cpl_rd    = 5'd4;
      applyStimulus();
      checkOutput("tp_cpl_issue", 64'(bus.dec_stall), 64'd0);
      advanceClock();
      issueLong(5'd6);
      applyStimulus();
      checkOutput("tp_still_full", 64'(bus.dec_stall), 64'd1);
      advanceClock();
      phase = "waw";
      issueLong(5'd5);
      bus.dec_long = 1'b0;
      applyStimulus();
      checkOutput("tp_waw", 64'(bus.dec_sb_use), 64'd1);
      advanceClock();
      phase = "flush";
      issueLong(5'd6);
      bus.dec_flush     = 1'b1;
      bus.lng_cpl_valid = 1'b1;
      bus.lng_cpl_rd    = 5'd3;
      applyStimulus(); advanceClock();
      issueLong(5'd3); applyStimulus(); advanceClock();

      // Asynchronous reset with x3 pending.
      phase = "async_reset";
      clearInputs();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("tp_sb_cleared", 64'(bus.sb_pending), 64'd0);
      modelReset();
      applyStimulus();
      advanceClock();
      rst_n = 1'b1;
      bus.dec_valid   = 1'b1;
      bus.dec_rs[4:0] = 5'd3;
      bus.dec_rs_renb = 2'b01;
      applyStimulus();
      checkOutput("tp_x3_free", 64'(bus.dec_stall), 64'd0);
      advanceClock();
      clearInputs();
      bus.lng_cpl_valid = 1'b1;
      bus.lng_cpl_rd    = 5'd3;
      applyStimulus(); advanceClock();
      issueLong(5'd10); applyStimulus(); advanceClock();
      issueLong(5'd11); applyStimulus(); advanceClock();
      issueLong(5'd12);
      applyStimulus();
      checkOutput("tp_no_underflow", 64'(bus.dec_sb_use), 64'd1);
      advanceClock();

      // Random traffic over a small register window to provoke collisions.
      phase = "random";
      for (int n = 0; n < 400; n++) begin
         bus.dec_valid      = ($urandom_range(0, 3) != 0);
         bus.dec_rs         = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         bus.dec_rs_renb    = 2'($urandom_range(0, 3));
         bus.dec_rdata      = {$urandom, $urandom};
         bus.dec_rd         = 5'($urandom_range(0, 7));
         bus.dec_rd_wenb    = ($urandom_range(0, 1) != 0);
         bus.dec_long       = ($urandom_range(0, 2) == 0);
         bus.dec_flush      = ($urandom_range(0, 7) == 0);
         bus.exe_rd         = 5'($urandom_range(0, 7));
         bus.exe_rd_wenb    = ($urandom_range(0, 1) != 0);
         bus.exe_result     = $urandom;
         bus.exe_load       = ($urandom_range(0, 3) == 0);
         bus.exe_csr        = ($urandom_range(0, 7) == 0);
         bus.fwd_rd         = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         bus.fwd_wenb       = 2'($urandom_range(0, 3));
         bus.fwd_result     = {$urandom, $urandom};
         bus.lng_cpl_valid  = ($urandom_range(0, 2) == 0);
         bus.lng_cpl_rd     = 5'($urandom_range(0, 7));
         bus.lng_cpl_result = $urandom;
         applyStimulus();
         advanceClock();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised DEC-stage hazard unit for the RISC-V pipeline. It forwards results from EXE and a configurable number of later stages to any number of DEC source operands. It stalls DEC on load-use and CSR-use hazards. It also keeps a 32-entry scoreboard of registers awaiting long-latency results (divider, and any later multi-cycle units), with an outstanding-operation limit.

## Interface
Parameters:
- XLEN, 32, datapath width
- NUM_RS, 2, DEC source operands (index i uses bits [5i+4:5i] and [XLEN*i+XLEN-1:XLEN*i])
- NUM_FWD, 2, forwarding stages after EXE, index 0 nearest (MEM, then WRB, ...)
- LNG_DEPTH, 2, max outstanding long-latency ops (1..15)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- dec_valid  in  1  DEC holds a valid instruction
- dec_rs  in  5*NUM_RS  source register addresses
- dec_rs_renb  in  NUM_RS  source i is used
- dec_rdata  in  XLEN*NUM_RS  register-file read data
- dec_rd  in  5  DEC destination register
- dec_rd_wenb  in  1  DEC writes rd
- dec_long  in  1  DEC instruction is long-latency
- dec_flush  in  1  DEC instruction is killed this cycle
- exe_rd, exe_rd_wenb, exe_result  in  5/1/XLEN  EXE destination and result
- exe_load  in  1  EXE is a load
- exe_csr  in  1  EXE is a CSRRx
- fwd_rd  in  5*NUM_FWD  later-stage destinations
- fwd_wenb  in  NUM_FWD  later-stage write enables
- fwd_result  in  XLEN*NUM_FWD  later-stage results
- lng_cpl_valid  in  1  a long op completes this cycle
- lng_cpl_rd  in  5  completing destination
- lng_cpl_result  in  XLEN  completing result
- dec_stall  out  1  stall DEC
- dec_load_use  out  1  stall caused by a load in EXE
- dec_csr_use  out  1  stall caused by a CSR op in EXE
- dec_sb_use  out  1  stall caused by the scoreboard or LNG_DEPTH
- dec_rs_data  out  XLEN*NUM_RS  operand values for EXE
- sb_pending  out  32  scoreboard bits (bit 0 is always 0)
- stall_cycles  out  32  stall performance counter (see Configuration)

## Operation
- Match for source i: dec_rs_renb[i] and the stage's wenb are both set, the addresses are equal, and rs is not x0. x0 never forwards and never stalls.
- Forward priority per source: EXE, then fwd[0] … fwd[NUM_FWD-1], then the lng_cpl port, then dec_rdata.
- EXE match with exe_load or exe_csr: no forward. Set dec_stall and the matching cause flag. This applies uniformly to every source.
- Scoreboard hit: sb_pending[rs] is set for a used source and lng_cpl does not deliver that rd this cycle. Result: stall with dec_sb_use.
- WAW: dec_rd_wenb is set and sb_pending[dec_rd] is set with no same-cycle completion. Result: stall with dec_sb_use.
- Structural: dec_long is set and outstanding == LNG_DEPTH with no completion this cycle. Result: stall with dec_sb_use.
- Cause flags are independent, and more than one may be set. dec_stall is the OR of all cause flags, gated by dec_valid.
- Issue: dec_valid & dec_long & dec_rd_wenb & ~dec_stall & ~dec_flush, and dec_rd ≠ 0. On issue, sb_pending[dec_rd] is set and outstanding increments.
- Completion: lng_cpl_valid clears sb_pending[lng_cpl_rd] and decrements outstanding.
- Issue and completion in the same cycle: outstanding is unchanged. If both target the same rd, the set wins.
- dec_flush never clears the scoreboard. In-flight long ops still complete.

## Timing
- All stall, cause and data outputs are combinational from the current-cycle inputs and registered state.
- sb_pending and outstanding update on posedge clk.
- A completing result is forwarded in the cycle lng_cpl_valid is high. The scoreboard bit reads clear from the next cycle.
- Reset (rst_n low, async): sb_pending = 0, outstanding = 0, stall_cycles = 0.
- Reset mid-operation discards all pending entries. Later lng_cpl pulses for discarded entries are harmless, and the decrement saturates at 0.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cycles counts clock cycles with dec_stall = 1. The count saturates at 0xFFFF_FFFF and resets to 0.
- HAZARD_PERF_CNT_EN undefined: stall_cycles is tied to 0 and no counter flops are built.

## Test plan
- rs1 = 5 in DEC; exe_rd = 5, wenb = 1, exe_result = 0xAA, and fwd[0] also rd = 5 with 0xBB -> dec_rs_data[0] = 0xAA, dec_stall = 0.
- exe_load = 1, exe_rd = 7; DEC rs2 = 7 used -> dec_stall = 1, dec_load_use = 1. Same case with rs2 = 0 -> no stall.
- Issue DIV to x9 (dec_long = 1). Next cycle DEC reads x9 -> dec_sb_use = 1 and stalls until lng_cpl_valid with rd = 9 and 0x1234. In that cycle: forward 0x1234, no stall; sb_pending[9] = 0 on the following cycle.
- LNG_DEPTH = 2: issue long ops to x3 and x4, then a third dec_long -> stall. A completion in the same cycle -> issue proceeds, and outstanding stays at 2.
- Assert rst_n = 0 with sb_pending[3] set -> sb_pending = 0 immediately, and no later stall on x3.
- With the macro defined, 4 stall cycles -> stall_cycles = 4. With the macro undefined -> 0.
